// File: rtl/data_reshuffler_pkg.sv
// Shared types for the data reshuffler stream: reshuffle modes and control FSM states.
package data_reshuffler_pkg;

  typedef enum logic [1:0] {
    PASS           = 2'd0,
    TRANSPOSE      = 2'd1,
    ANTI_TRANSPOSE = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/data_reshuffler_stream_if.sv
// Tile streaming interface: a (input tile) and z (reshuffled tile) valid/ready channels.
// A beat transfers on a rising edge where valid and ready are both 1; the sender holds
// its data stable while valid=1 and ready=0, and ready never depends on a same-cycle pop.
interface data_reshuffler_stream_if #(
  parameter int SpatPar   = 8,
  parameter int DataWidth = 64
);
  logic [SpatPar*DataWidth-1:0] a_i;
  logic                         a_valid_i;
  logic                         a_ready_o;
  logic [SpatPar*DataWidth-1:0] z_o;
  logic                         z_valid_o;
  logic                         z_ready_i;

  modport master (
    output a_i, a_valid_i, z_ready_i,
    input  a_ready_o, z_o, z_valid_o
  );

  modport slave (
    input  a_i, a_valid_i, z_ready_i,
    output a_ready_o, z_o, z_valid_o
  );
endinterface

// File: rtl/data_reshuffler_stream_fifo.sv
// Output buffer for reshuffled tiles: power-of-two circular FIFO, head shown as zero when empty.
module reshuffle_fifo #(
  parameter int Width = 8,
  parameter int Depth = 4,
  localparam int PtrW = $clog2(Depth),
  localparam int CntW = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o
);
  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = empty_o ? '0 : mem_q[rptr_q];

  // Pointers wrap naturally because Depth is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end
endmodule

// File: rtl/data_reshuffler_stream.sv
// Job-driven tile reshuffler: permutes each accepted SpatPar x SpatPar tile and buffers it for output.
module data_reshuffler_stream
  import data_reshuffler_pkg::*;
#(
  parameter int SpatPar   = 8,
  parameter int DataWidth = 64,
  parameter int FifoDepth = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  data_reshuffler_stream_if.slave            bus,
  input  logic [1:0]                         csr_mode_i,
  input  logic [31:0]                        csr_num_beats_i,
  input  logic                               csr_valid_i,
  output logic                               csr_ready_o,
  output logic                               busy_o,
  output logic                               done_o,
  output logic [$clog2(FifoDepth+1)-1:0]     fifo_count_o,
  output logic [1:0]                         dbg_state_o
);
  localparam int Elems = DataWidth / SpatPar;
  localparam int TileW = SpatPar * DataWidth;

  state_e      state_q, state_d;
  logic [1:0]  mode_q, mode_d;
  logic [31:0] beats_q, beats_d;
  logic        done_q, done_d;
  logic        a_ready, push, full, empty;
  logic [TileW-1:0] tile_z;

  // Permutation selected by the mode latched at job launch; reserved mode 3 falls to passthrough.
  always_comb begin
    tile_z = '0;
    for (int i = 0; i < SpatPar; i++) begin
      for (int j = 0; j < SpatPar; j++) begin
        int src;
        src = i * SpatPar + j;
        case (mode_q)
          TRANSPOSE:      src = j * SpatPar + i;
          ANTI_TRANSPOSE: src = (SpatPar - 1 - j) * SpatPar + (SpatPar - 1 - i);
          default:        src = i * SpatPar + j;
        endcase
        tile_z[(i*SpatPar+j)*Elems +: Elems] = bus.a_i[src*Elems +: Elems];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      mode_q  <= PASS;
      beats_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      beats_q <= beats_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    beats_d     = beats_q;
    done_d      = 1'b0;
    csr_ready_o = 1'b0;
    a_ready     = 1'b0;
    busy_o      = 1'b0;
    unique case (state_q)
      IDLE: begin
        csr_ready_o = 1'b1;
        if (csr_valid_i) begin
          mode_d  = csr_mode_i;
          beats_d = csr_num_beats_i;
          if (csr_num_beats_i == 32'd0) done_d  = 1'b1;
          else                          state_d = RUN;
        end
      end
      RUN: begin
        busy_o  = 1'b1;
        a_ready = !full;
        if (bus.a_valid_i && a_ready) begin
          beats_d = beats_q - 32'd1;
          if (beats_q == 32'd1) state_d = DRAIN;
        end
      end
      DRAIN: begin
        busy_o = 1'b1;
        if (empty) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign push          = bus.a_valid_i && a_ready;
  assign bus.a_ready_o = a_ready;
  assign bus.z_valid_o = !empty;
  assign done_o        = done_q;
  assign dbg_state_o   = state_q;

  reshuffle_fifo #(
    .Width (TileW),
    .Depth (FifoDepth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (tile_z),
    .pop_i   (bus.z_ready_i),
    .data_o  (bus.z_o),
    .full_o  (full),
    .empty_o (empty),
    .count_o (fifo_count_o)
  );
endmodule

// File: tb/tb_data_reshuffler_stream.sv
// Scoreboard bench for data_reshuffler_stream: directed jobs per mode, backpressure, zero-length and reset.
module tb_data_reshuffler_stream;
  localparam int S  = 8;
  localparam int DW = 64;
  localparam int FD = 4;
  localparam int TW = S * DW;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  csr_mode = '0;
  logic [31:0] csr_num = '0;
  logic        csr_valid = 1'b0;
  logic        csr_ready, busy, done;
  logic [2:0]  fifo_count;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad = 0;
  logic [TW-1:0] exp_q[$];
  int  acc_cnt = 0;
  int  out_cnt = 0;
  int  max_cnt = 0;
  bit  rand_ready_en = 1'b0;
  bit  ready_fixed = 1'b0;
  bit  sender_done = 1'b0;

  always #5 clk = ~clk;

  data_reshuffler_stream_if #(.SpatPar(S), .DataWidth(DW)) bus ();

  data_reshuffler_stream #(.SpatPar(S), .DataWidth(DW), .FifoDepth(FD)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .bus             (bus.slave),
    .csr_mode_i      (csr_mode),
    .csr_num_beats_i (csr_num),
    .csr_valid_i     (csr_valid),
    .csr_ready_o     (csr_ready),
    .busy_o          (busy),
    .done_o          (done),
    .fifo_count_o    (fifo_count),
    .dbg_state_o     (dbg_state)
  );

  // kind 0: a(i,j)=base+8i+j; kind 1: its transpose; kind 2: its anti-transpose.
  function automatic logic [TW-1:0] make_tile(int base, int kind);
    logic [TW-1:0] t = '0;
    for (int i = 0; i < S; i++) begin
      for (int j = 0; j < S; j++) begin
        int v;
        case (kind)
          1:       v = base + j * 8 + i;
          2:       v = base + (7 - j) * 8 + (7 - i);
          default: v = base + i * 8 + j;
        endcase
        t[(i*S+j)*8 +: 8] = 8'(v);
      end
    end
    return t;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_launch(logic [1:0] mode, logic [31:0] n);
    int k = 0;
    csr_mode  = mode;
    csr_num   = n;
    csr_valid = 1'b1;
    @(negedge clk);
    while (!csr_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("csr_ready_wait", 32'(csr_ready), 32'd1);
    step();
    csr_valid = 1'b0;
  endtask

  task automatic send(logic [TW-1:0] data);
    int k = 0;
    bus.a_i       = data;
    bus.a_valid_i = 1'b1;
    @(negedge clk);
    while (!bus.a_ready_o && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("a_ready_wait", 32'(bus.a_ready_o), 32'd1);
    step();
    bus.a_valid_i = 1'b0;
  endtask

  task automatic wait_done(string name, int bound);
    int k = 0;
    @(negedge clk);
    while (!done && k < bound) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'(done), 32'd1);
    @(negedge clk);
    check({name, "_pulse"}, 32'(done), 32'd0);
    step();
  endtask

  // Single driver for z_ready_i: fixed level or random backpressure.
  initial begin
    bus.z_ready_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.z_ready_i = rand_ready_en ? 1'($urandom_range(0, 1)) : ready_fixed;
    end
  end

  // Monitor: pops the expected queue on every output transfer and checks hold-while-stalled.
  initial begin
    logic [TW-1:0] held = '0;
    logic [TW-1:0] e;
    bit stalled = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled = 1'b0;
      end else begin
        if (bus.z_valid_o && bus.z_ready_i) begin
          total++;
          out_cnt++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL z_unexpected: got %h expected no output", bus.z_o);
          end else begin
            e = exp_q.pop_front();
            if (bus.z_o !== e) begin
              bad++;
              $display("FAIL z_data: got %h expected %h", bus.z_o, e);
            end
          end
        end
        if (stalled) begin
          total++;
          if (bus.z_o !== held) begin
            bad++;
            $display("FAIL z_stable: got %h expected %h", bus.z_o, held);
          end
        end
        stalled = bus.z_valid_o && !bus.z_ready_i;
        held    = bus.z_o;
        if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
        if (bus.a_valid_i && bus.a_ready_o) acc_cnt++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a0, o0, k, seen;
    logic [TW-1:0] d;
    bus.a_i       = '0;
    bus.a_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_a_ready", 32'(bus.a_ready_o), 32'd0);
    check("rst_z_valid", 32'(bus.z_valid_o), 32'd0);
    check("rst_z_zero", 32'(|bus.z_o), 32'd0);
    check("rst_csr_ready", 32'(csr_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    step();

    // Transpose, single beat: visible one cycle after acceptance, done after the pop.
    ready_fixed = 1'b1;
    repeat (2) step();
    csr_launch(2'd1, 32'd1);
    exp_q.push_back(make_tile(0, 1));
    send(make_tile(0, 0));
    @(negedge clk);
    check("t1_latency_valid", 32'(bus.z_valid_o), 32'd1);
    check("t1_count", 32'(fifo_count), 32'd1);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_no_early_done", 32'(done), 32'd0);
    wait_done("t1_done", 20);
    check("t1_idle_busy", 32'(busy), 32'd0);

    // Anti-transpose, four back-to-back beats with a free-running sink.
    csr_launch(2'd2, 32'd4);
    max_cnt = 0;
    o0 = out_cnt;
    for (int b = 0; b < 4; b++) begin
      exp_q.push_back(make_tile(64 * b, 2));
      send(make_tile(64 * b, 0));
    end
    wait_done("t2_done", 20);
    check("t2_max_count", 32'(max_cnt), 32'd1);
    check("t2_out_cnt", 32'(out_cnt - o0), 32'd4);

    // Stalled sink: only FifoDepth of six beats fit until the sink is released.
    ready_fixed = 1'b0;
    repeat (2) step();
    csr_launch(2'd0, 32'd6);
    a0 = acc_cnt;
    o0 = out_cnt;
    for (int b = 0; b < 6; b++) exp_q.push_back(make_tile(17 * b, 0));
    sender_done = 1'b0;
    fork
      begin
        for (int b = 0; b < 6; b++) send(make_tile(17 * b, 0));
        sender_done = 1'b1;
      end
    join_none
    repeat (10) step();
    @(negedge clk);
    check("t3_accepted", 32'(acc_cnt - a0), 32'd4);
    check("t3_full_count", 32'(fifo_count), 32'd4);
    check("t3_full_a_ready", 32'(bus.a_ready_o), 32'd0);
    check("t3_full_z_valid", 32'(bus.z_valid_o), 32'd1);
    step();
    ready_fixed = 1'b1;
    k = 0;
    while (!sender_done && k < 200) begin
      step();
      k++;
    end
    check("t3_sender_done", 32'(sender_done), 32'd1);
    wait_done("t3_done", 50);
    check("t3_out_cnt", 32'(out_cnt - o0), 32'd6);

    // Zero-length job: immediate done, never busy, no input taken.
    a0 = acc_cnt;
    bus.a_i       = make_tile(5, 0);
    bus.a_valid_i = 1'b1;
    csr_launch(2'd0, 32'd0);
    @(negedge clk);
    check("t4_done", 32'(done), 32'd1);
    check("t4_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("t4_done_pulse", 32'(done), 32'd0);
    check("t4_busy_after", 32'(busy), 32'd0);
    check("t4_no_accept", 32'(acc_cnt - a0), 32'd0);
    step();
    bus.a_valid_i = 1'b0;

    // Reset mid-job with three tiles buffered.
    ready_fixed = 1'b0;
    repeat (2) step();
    csr_launch(2'd0, 32'd5);
    for (int b = 0; b < 3; b++) send(make_tile(30 * b, 0));
    @(negedge clk);
    check("t5_count_pre", 32'(fifo_count), 32'd3);
    check("t5_busy_pre", 32'(busy), 32'd1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("t5_z_valid", 32'(bus.z_valid_o), 32'd0);
    check("t5_count", 32'(fifo_count), 32'd0);
    check("t5_csr_ready", 32'(csr_ready), 32'd1);
    check("t5_done", 32'(done), 32'd0);
    check("t5_z_zero", 32'(|bus.z_o), 32'd0);
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("t5_no_done", 32'(seen), 32'd0);
    step();

    // Reserved mode with random backpressure: behaves as passthrough, order kept.
    rand_ready_en = 1'b1;
    csr_launch(2'd3, 32'd100);
    o0 = out_cnt;
    for (int b = 0; b < 100; b++) begin
      for (int w = 0; w < TW / 32; w++) d[w*32 +: 32] = $urandom();
      exp_q.push_back(d);
      send(d);
    end
    wait_done("t6_done", 1000);
    rand_ready_en = 1'b0;
    check("t6_out_cnt", 32'(out_cnt - o0), 32'd100);

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
